// File: rtl/shift_pkg.sv
// Shared types and encodings for the shift decode/issue stage and the downstream shifter.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned RD_W    = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ILL = 2'd3
  } shift_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
    logic [RD_W-1:0]    rd;
    logic               illegal;
  } shift_issue_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// Upstream instruction handshake and downstream shifter-issue handshake of the stage.
interface shift_issue_stage_if;
  import shift_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instr;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_a;
  logic [SHAMT_W-1:0] out_shamt;
  shift_op_e          out_op;
  logic [RD_W-1:0]    out_rd;
  logic               out_illegal;

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_shamt, out_op, out_rd, out_illegal
  );

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_shamt, out_op, out_rd, out_illegal
  );

endinterface

// File: rtl/shift_decode.sv
// Combinational decode of RV32I register/immediate shifts into an issue payload.
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output shift_issue_t    issue_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_imm;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign is_imm = (opcode == OPC_OPIMM);

  // rs1 index comes from the register file port; upper rs2 bits never affect the shift
  assign unused_fields = ^{instr_i[19:15], rs2_data_i[XLEN-1:SHAMT_W]};

  always_comb begin
    issue_o       = '0;
    issue_o.a     = rs1_data_i;
    issue_o.rd    = instr_i[11:7];
    issue_o.shamt = is_imm ? instr_i[24:20] : rs2_data_i[SHAMT_W-1:0];
    issue_o.op    = SH_ILL;
    // funct7 check also rejects immediate shamt >= 32 (instr[25] set)
    if ((opcode == OPC_OP) || is_imm) begin
      if ((funct3 == F3_SLL) && (funct7 == F7_BASE)) begin
        issue_o.op = SH_SLL;
      end else if ((funct3 == F3_SR) && (funct7 == F7_BASE)) begin
        issue_o.op = SH_SRL;
      end else if ((funct3 == F3_SR) && (funct7 == F7_ALT)) begin
        issue_o.op = SH_SRA;
      end
    end
    issue_o.illegal = (issue_o.op == SH_ILL);
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift decode/issue stage: decoded instructions queued in a main+skid pair ahead of the shifter.
module shift_issue_stage
  import shift_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  shift_issue_stage_if.slave bus
);

  shift_issue_t dec;
  shift_issue_t main_q, main_d;
  shift_issue_t skid_q, skid_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         issue;

  shift_decode u_decode (
    .instr_i    (bus.instr),
    .rs1_data_i (bus.rs1_data),
    .rs2_data_i (bus.rs2_data),
    .issue_o    (dec)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign issue  = main_valid_q && bus.out_ready;

  // Next-state for the main/skid pair; accept implies skid is empty
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (issue) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    if (accept) begin
      if (!main_valid_d) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_a       = main_q.a;
  assign bus.out_shamt   = main_q.shamt;
  assign bus.out_op      = main_q.op;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: randomized and directed instruction streams.
module tb_shift_issue_stage;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] a;
    int          shamt;
    int          op;      // 0=SLL 1=SRL 2=SRA 3=ILL
    int          rd;
    bit          illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  shift_issue_stage_if bus ();

  shift_issue_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  exp_t scb[$];
  int   total = 0;
  int   bad = 0;
  int   issue_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    int opc, f3, f7;
    bit imm, regf;
    opc  = int'(ins & 32'h7f);
    f3   = int'((ins >> 12) & 32'h7);
    f7   = int'((ins >> 25) & 32'h7f);
    imm  = (opc == 'h13);
    regf = (opc == 'h33);
    e.a     = rs1;
    e.rd    = int'((ins >> 7) & 32'h1f);
    e.shamt = imm ? int'((ins >> 20) & 32'h1f) : int'(rs2 % 32);
    e.op    = 3;
    if (imm || regf) begin
      if (f3 == 1 && f7 == 0)         e.op = 0;
      else if (f3 == 5 && f7 == 0)    e.op = 1;
      else if (f3 == 5 && f7 == 'h20) e.op = 2;
    end
    if (imm && ((ins >> 25) & 32'h1) != 0) e.op = 3;
    e.illegal = (e.op == 3);
    return e;
  endfunction

  function automatic logic [31:0] enc(input int f7, input int rs2, input int rs1, input int f3,
                                      input int rd, input int opc);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc);
  endfunction

  function automatic logic [31:0] rand_instr();
    int rd, rs1, k;
    rd  = int'($urandom_range(0, 31));
    rs1 = int'($urandom_range(0, 31));
    k   = int'($urandom_range(0, 5));
    case (k)
      0: return enc(0, int'($urandom_range(0, 31)), rs1, 1, rd, 'h33);
      1: return enc(($urandom_range(0, 1) != 0) ? 'h20 : 0, int'($urandom_range(0, 31)), rs1, 5, rd, 'h33);
      2: return enc(0, int'($urandom_range(0, 31)), rs1, 1, rd, 'h13);
      3: return enc(($urandom_range(0, 1) != 0) ? 'h20 : 0, int'($urandom_range(0, 31)), rs1, 5, rd, 'h13);
      4: return enc(int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), rs1,
                    ($urandom_range(0, 1) != 0) ? 5 : 1, rd, 'h13);
      default: return $urandom;
    endcase
  endfunction

  // One clock of stimulus; occupancy of the scoreboard predicts in_ready/out_valid
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] rs1,
                       input logic [31:0] rs2, input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.rs1_data  = rs1;
    bus.rs2_data  = rs2;
    bus.out_ready = ordy && !fl;
    flush         = fl;
    @(negedge clk);
    if (iv && bus.in_ready === 1'b1 && !fl) scb.push_back(model(ins, rs1, rs2));
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (fl) scb.delete();
    chk("in_ready", 32'(bus.in_ready), 32'(scb.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(scb.size() > 0));
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b1;
    bus.instr     = enc(0, 3, 1, 1, 9, 'h33);
    bus.rs1_data  = $urandom;
    bus.rs2_data  = $urandom;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    scb.delete();
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_a", 32'(bus.out_a), 32'd0);
    chk("rst out_shamt", 32'(bus.out_shamt), 32'd0);
    chk("rst out_op", 32'(bus.out_op), 32'd0);
    chk("rst out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst out_illegal", 32'(bus.out_illegal), 32'd0);
    rst = 1'b0;
  endtask

  // Monitor: compares every issued entry against the oldest expected one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        issue_cnt++;
        if (scb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue: got an unexpected entry rd=%0d, expected none at %0t", bus.out_rd, $time);
        end else begin
          e = scb.pop_front();
          chk("out_a", bus.out_a, e.a);
          chk("out_op", 32'(bus.out_op), 32'(e.op));
          chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
          chk("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
          if (!e.illegal) chk("out_shamt", 32'(bus.out_shamt), 32'(e.shamt));
        end
      end
    end
  end

  initial begin
    int base;
    do_reset();

    // Directed decode cases
    cycle(1, 32'h40235293, 32'h40000000, $urandom, 1, 0);
    cycle(1, 32'h003110B3, $urandom, 32'hFFFFFFE7, 1, 0);
    cycle(1, 32'h02001013, $urandom, $urandom, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Backpressure: fill main and skid, hold the third upstream, then drain without bubbles
    cycle(1, enc(0, 1, 2, 1, 10, 'h13), 32'h11, 0, 0, 0);
    cycle(1, enc(0, 2, 3, 5, 11, 'h13), 32'h22, 0, 0, 0);
    cycle(1, enc('h20, 3, 4, 5, 12, 'h13), 32'h33, 0, 0, 0);
    cycle(1, enc('h20, 3, 4, 5, 12, 'h13), 32'h33, 0, 0, 0);
    base = issue_cnt;
    cycle(1, enc('h20, 3, 4, 5, 12, 'h13), 32'h33, 0, 1, 0);
    cycle(1, enc('h20, 3, 4, 5, 12, 'h13), 32'h33, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("three in a row", 32'(issue_cnt - base), 32'd3);

    // Flush and reset with both entries full and a valid input pending
    cycle(1, rand_instr(), $urandom, $urandom, 0, 0);
    cycle(1, rand_instr(), $urandom, $urandom, 0, 0);
    cycle(1, rand_instr(), $urandom, $urandom, 0, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, rand_instr(), $urandom, $urandom, 0, 0);
    cycle(1, rand_instr(), $urandom, $urandom, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 1, 0);

    // Full shamt sweep at one instruction per clock
    base = issue_cnt;
    for (int s = 0; s < 32; s++) cycle(1, enc(0, s, 7, 5, s, 'h13), $urandom, $urandom, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("sweep issues", 32'(issue_cnt - base), 32'd32);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end

    for (int i = 0; i < 10 && scb.size() != 0; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("drained", 32'(scb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Decode/issue stage directly upstream of the combinational RV32I shifter (operand a, shift amount shamt, result b). It accepts instructions plus register-file read data, decodes SLL/SRL/SRA and SLLI/SRLI/SRAI, and selects shamt from rs2[4:0] or instr[24:20]. It registers the operand, shamt, op, rd and illegal flag into a 2-entry skid buffer behind a valid/ready handshake. Output drives the shifter inputs and carries rd/op for writeback.

Parameters:
XLEN, 32, operand width; fixed at 32 for RV32I, other values unsupported.
SHAMT_W, 5, shift-amount width, equal to $clog2(XLEN).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush, empties both entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; registered
instr  in  32  raw instruction word
rs1_data  in  XLEN  rs1 read value
rs2_data  in  XLEN  rs2 read value
out_valid  out  1  issued entry valid
out_ready  in  1  shifter/writeback accepts
out_a  out  XLEN  operand to shifter (rs1_data)
out_shamt  out  SHAMT_W  shift amount
out_op  out  2  shift_op_e: SH_SLL, SH_SRL, SH_SRA, SH_ILL
out_rd  out  5  destination register, instr[11:7]
out_illegal  out  1  decode fault; out_op is SH_ILL

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. While rst is high at a rising edge, both entries are invalidated.
- Reset values after any reset edge: out_valid=0, out_a=0, out_shamt=0, out_op=SH_SLL, out_rd=0, out_illegal=0, in_ready=1.
- flush has the same effect as rst on valids and in_ready. Payload registers may hold stale data; they are don't-care while out_valid=0. flush has priority over a same-cycle input handshake, and that input is dropped.
- Decode is combinational on instr and registered on accept:
  - opcode 0110011, funct3 001, funct7 0000000 -> SH_SLL, shamt=rs2_data[4:0].
  - opcode 0110011, funct3 101, funct7 0000000 -> SH_SRL; funct7 0100000 -> SH_SRA; shamt=rs2_data[4:0].
  - opcode 0010011, funct3 001 or 101: same funct7 rules, with shamt=instr[24:20].
  - For the immediate forms, instr[25]=1 (shamt >= 32) is illegal.
  - Anything else gives SH_ILL with out_illegal=1. The entry still issues, because the exception is taken downstream.
  - For register shifts, rs2_data[31:5] is ignored.
- Handshake: transfer on in_valid&&in_ready; issue on out_valid&&out_ready. out_* stay stable while out_valid=1 and out_ready=0.
- Storage is a main register plus a skid register; outputs always come from main.
  - Accept when main is empty, or main is draining this cycle: write main. Latency is 1 cycle, and the new entry is visible on the next edge.
  - Accept when main is held (out_ready=0): write skid.
  - Issue when skid is valid: skid moves to main on the same edge.
  - Simultaneous accept and issue with skid empty: main is overwritten with the new entry and no bubble is inserted.
  - in_ready (registered) = !skid_valid_next. With both entries full, in_ready=0 until an issue occurs.
- Ordering is strictly FIFO, and no entry is ever dropped or duplicated except on rst/flush.
- Throughput is 1 instruction/cycle when out_ready is held high.

Decomposition:
- Package shift_pkg holds: typedef enum logic[1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ILL}; opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011; F3_SLL=3'b001 and F3_SR=3'b101; F7_BASE=7'b0000000 and F7_ALT=7'b0100000; struct shift_issue_t {a, shamt, op, rd, illegal}.
- Sub-module shift_decode is purely combinational: instr, rs2_data -> shift_issue_t fields. The shifter reuses shift_op_e from the package.

Test Plan:
1. Reset, then instr=0x40235293 (SRAI x5,x6,2), rs1_data=0x40000000, out_ready=1 -> next cycle out_valid=1, out_op=SH_SRA, out_shamt=2, out_rd=5, out_a=0x40000000, out_illegal=0.
2. instr=0x003110B3 (SLL x1,x2,x3), rs2_data=0xFFFFFFE7 -> out_op=SH_SLL, out_shamt=7, out_rd=1.
3. instr=0x02001013 (SLLI, instr[25]=1) -> out_op=SH_ILL, out_illegal=1, and the entry still issues.
4. Backpressure: hold out_ready=0 while streaming 3 instructions -> main and skid fill, in_ready=0 after the second accept, and the 3rd is held upstream. Raise out_ready -> all 3 issue in order on 3 consecutive cycles with no bubble.
5. With both entries full, assert flush (or rst) with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input is not captured.
6. Sweep shamt 0..31 via SRLI with out_ready=1 every cycle -> 32 consecutive issues, each with out_shamt equal to the encoded value.
